// File: rtl/ili9341_spi_display_model.sv
// rtl/ili9341_spi_display_model.sv - ILI9341 4-wire SPI peripheral model writing RGB565 pixels to VRAM
//
// Purpose: receives SPI bytes (mode 0, MSB first) in the clk domain and decodes
// NOP/SWRESET/CASET/PASET/RAMWR into pixel writes on a VRAM write port.
// Ports:
//   clk, rstb                       system clock (>= 4x spi_clk), async active-low reset
//   spi_csb, spi_clk, spi_mosi      SPI pins, synchronised internally
//   data_commandb                   1 = data byte, 0 = command byte
//   vram_wr_ena/addr/data, vsync    pixel write port; vsync marks the last pixel of the window
//   cmd_valid, cmd_byte             command byte strobe and last command byte
//   protocol_error                  pulse on a malformed sequence
module ili9341_spi_display_model #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      spi_csb,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      data_commandb,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output logic [15:0]               vram_wr_data,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_byte,
    output logic                      vsync,
    output logic                      protocol_error
);
    localparam int AW = $clog2(VRAM_L);
    localparam logic [8:0]  EC_RST = 9'(DISPLAY_WIDTH - 1);
    localparam logic [8:0]  EP_RST = 9'(DISPLAY_HEIGHT - 1);
    localparam logic [15:0] W16    = 16'(DISPLAY_WIDTH);
    localparam logic [15:0] H16    = 16'(DISPLAY_HEIGHT);

    typedef enum logic [2:0] {S_CMD, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

    // [0],[1] are the synchroniser stages; [2] is the previous synced value for edge detect
    logic [2:0] sclk_sync_q, csb_sync_q;
    logic [1:0] mosi_sync_q, dc_sync_q;
    logic [6:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic       byte_vld_q, byte_dc_q;
    logic [7:0] byte_q;

    logic sclk_rise, csb_rise, shift_en;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign csb_rise  = csb_sync_q[1] & ~csb_sync_q[2];
    // A clock edge coinciding with the csb rise still counts, so an 8th bit there completes the byte
    assign shift_en  = sclk_rise & (~csb_sync_q[1] | csb_rise);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= 3'b111;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_vld_q  <= 1'b0;
            byte_dc_q   <= 1'b0;
            byte_q      <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
            csb_sync_q  <= {csb_sync_q[1:0], spi_csb};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            dc_sync_q   <= {dc_sync_q[0], data_commandb};
            byte_vld_q  <= 1'b0;
            if (shift_en) begin
                shreg_q <= {shreg_q[5:0], mosi_sync_q[1]};
                if (bit_cnt_q == 3'd7) begin
                    byte_vld_q <= 1'b1;
                    byte_q     <= {shreg_q, mosi_sync_q[1]};
                    byte_dc_q  <= dc_sync_q[1];
                    bit_cnt_q  <= '0;
                end else begin
                    bit_cnt_q <= csb_rise ? 3'd0 : bit_cnt_q + 3'd1;
                end
            end else if (csb_rise) begin
                bit_cnt_q <= '0;
            end
        end
    end

    state_t      state_q, state_d;
    logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d, x_q, x_d, y_q, y_d;
    logic [1:0]  arg_cnt_q, arg_cnt_d;
    logic [23:0] arg_q, arg_d;
    logic        half_q, half_d;
    logic [7:0]  hi_q, hi_d;
    logic        wr_ena_q, wr_ena_d, vsync_q, vsync_d, cmd_vld_q, cmd_vld_d, perr_q, perr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;

    logic [15:0]   a_start, a_end;
    logic [AW-1:0] pix_addr;
    assign a_start  = arg_q[23:8];
    assign a_end    = {arg_q[7:0], byte_q};
    assign pix_addr = AW'(y_q) * AW'(DISPLAY_WIDTH) + AW'(x_q);

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        ec_d       = ec_q;
        sp_d       = sp_q;
        ep_d       = ep_q;
        x_d        = x_q;
        y_d        = y_q;
        arg_cnt_d  = arg_cnt_q;
        arg_d      = arg_q;
        half_d     = half_q;
        hi_d       = hi_q;
        wr_ena_d   = 1'b0;
        vsync_d    = 1'b0;
        cmd_vld_d  = 1'b0;
        perr_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cmd_byte_d = cmd_byte_q;
        if (byte_vld_q && !byte_dc_q) begin
            cmd_vld_d  = 1'b1;
            cmd_byte_d = byte_q;
            half_d     = 1'b0;
            arg_cnt_d  = '0;
            // Argument collection cut short by a new command
            if (state_q == S_CASET || state_q == S_PASET) perr_d = 1'b1;
            case (byte_q)
                8'h00: state_d = S_CMD;
                8'h01: begin
                    state_d = S_CMD;
                    sc_d = '0; ec_d = EC_RST; sp_d = '0; ep_d = EP_RST;
                    x_d = '0;  y_d = '0;
                end
                8'h2A: state_d = S_CASET;
                8'h2B: state_d = S_PASET;
                8'h2C: begin
                    state_d = S_RAMWR;
                    x_d = sc_q;
                    y_d = sp_q;
                end
                default: state_d = S_SKIP;
            endcase
        end else if (byte_vld_q) begin
            case (state_q)
                S_CMD: perr_d = 1'b1;
                S_CASET, S_PASET: begin
                    if (arg_cnt_q != 2'd3) begin
                        arg_d     = {arg_q[15:0], byte_q};
                        arg_cnt_d = arg_cnt_q + 2'd1;
                    end else begin
                        arg_cnt_d = '0;
                        state_d   = S_CMD;
                        if (a_start > a_end || a_end >= ((state_q == S_CASET) ? W16 : H16)) begin
                            perr_d = 1'b1;
                        end else if (state_q == S_CASET) begin
                            sc_d = a_start[8:0];
                            ec_d = a_end[8:0];
                        end else begin
                            sp_d = a_start[8:0];
                            ep_d = a_end[8:0];
                        end
                    end
                end
                S_RAMWR: begin
                    if (!half_q) begin
                        hi_d   = byte_q;
                        half_d = 1'b1;
                    end else begin
                        half_d   = 1'b0;
                        wr_ena_d = 1'b1;
                        addr_d   = pix_addr;
                        data_d   = {hi_q, byte_q};
                        if (x_q == ec_q) begin
                            x_d = sc_q;
                            if (y_q == ep_q) begin
                                y_d     = sp_q;
                                vsync_d = 1'b1;
                            end else begin
                                y_d = y_q + 9'd1;
                            end
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_CMD;
            sc_q       <= '0;
            ec_q       <= EC_RST;
            sp_q       <= '0;
            ep_q       <= EP_RST;
            x_q        <= '0;
            y_q        <= '0;
            arg_cnt_q  <= '0;
            arg_q      <= '0;
            half_q     <= 1'b0;
            hi_q       <= '0;
            wr_ena_q   <= 1'b0;
            vsync_q    <= 1'b0;
            cmd_vld_q  <= 1'b0;
            perr_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cmd_byte_q <= '0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            ec_q       <= ec_d;
            sp_q       <= sp_d;
            ep_q       <= ep_d;
            x_q        <= x_d;
            y_q        <= y_d;
            arg_cnt_q  <= arg_cnt_d;
            arg_q      <= arg_d;
            half_q     <= half_d;
            hi_q       <= hi_d;
            wr_ena_q   <= wr_ena_d;
            vsync_q    <= vsync_d;
            cmd_vld_q  <= cmd_vld_d;
            perr_q     <= perr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cmd_byte_q <= cmd_byte_d;
        end
    end

    assign vram_wr_ena    = wr_ena_q;
    assign vram_wr_addr   = addr_q;
    assign vram_wr_data   = data_q;
    assign cmd_valid      = cmd_vld_q;
    assign cmd_byte       = cmd_byte_q;
    assign vsync          = vsync_q;
    assign protocol_error = perr_q;
endmodule
